// File: rtl/imem_arbiter.sv
// Instruction RAM controller: arbitrates CPU fetch against a run-time loader on one single-port RAM.
// Optional address legality checking is enabled by defining IMEM_RANGE_CHECK_EN.
module imem_arbiter #(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_3000,
   parameter int          DEPTH_LOG2 = 12,
   parameter int          STARVE_MAX = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  f_req,
   input  logic [31:0]           f_pc,
   output logic                  f_gnt,
   output logic                  f_rvalid,
   output logic [31:0]           f_instr,
   output logic                  f_fault,
   input  logic                  l_req,
   input  logic [31:0]           l_addr,
   input  logic [31:0]           l_wdata,
   output logic                  l_gnt,
   output logic                  l_err,
   output logic                  ram_en,
   output logic                  ram_we,
   output logic [DEPTH_LOG2-1:0] ram_addr,
   output logic [31:0]           ram_wdata,
   input  logic [31:0]           ram_rdata
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RD   = 2'd1;
   localparam logic [1:0] ST_WT   = 2'd2;
   localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

   logic [1:0]            state_q, state_d;
   logic [2:0]            starve_q, starve_d;
   logic                  fault_q, fault_d;
   logic [31:0]           instr_q, instr_d;
   logic                  l_err_q, l_err_d;
   logic                  f_bad, l_bad;
   logic                  can_arb, l_win;
   logic [DEPTH_LOG2-1:0] f_idx, l_idx;

   assign f_idx = DEPTH_LOG2'((f_pc - BASE_ADDR) >> 2);
   assign l_idx = DEPTH_LOG2'((l_addr - BASE_ADDR) >> 2);

`ifdef IMEM_RANGE_CHECK_EN
   localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'd4 << DEPTH_LOG2);
   assign f_bad = (f_pc[1:0] != 2'b00) || (f_pc < BASE_ADDR) || ({1'b0, f_pc} >= END_ADDR);
   assign l_bad = (l_addr[1:0] != 2'b00) || (l_addr < BASE_ADDR) || ({1'b0, l_addr} >= END_ADDR);
`else
   assign f_bad = 1'b0;
   assign l_bad = 1'b0;
`endif

   // Read data arrives straight from the RAM in the RD cycle and is held afterwards.
   assign f_rvalid = reset && (state_q == ST_RD);
   assign f_instr  = f_rvalid ? (fault_q ? 32'h0000_0000 : ram_rdata) : instr_q;
   assign f_fault  = fault_q;
   assign l_err    = l_err_q;

   always_comb begin
      can_arb   = reset && (state_q != ST_WT);
      l_win     = l_req && (!f_req || (starve_q >= STARVE_LIM));
      f_gnt     = can_arb && f_req && !l_win;
      l_gnt     = can_arb && l_win;
      ram_en    = (f_gnt && !f_bad) || (l_gnt && !l_bad);
      ram_we    = l_gnt && !l_bad;
      ram_addr  = l_gnt ? l_idx : f_idx;
      ram_wdata = l_wdata;
   end

   always_comb begin
      state_d  = ST_IDLE;
      starve_d = starve_q;
      fault_d  = fault_q;
      instr_d  = f_instr;
      l_err_d  = l_gnt && l_bad;
      // An illegal write never touches the RAM, so it needs no turnaround.
      if (f_gnt) begin
         state_d = ST_RD;
         fault_d = f_bad;
      end else if (l_gnt && !l_bad) begin
         state_d = ST_WT;
      end
      if (!l_req || l_gnt) begin
         starve_d = 3'd0;
      end else if (starve_q != 3'd7) begin
         starve_d = starve_q + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         starve_q <= 3'd0;
         fault_q  <= 1'b0;
         instr_q  <= 32'h0000_0000;
         l_err_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         fault_q  <= fault_d;
         instr_q  <= instr_d;
         l_err_q  <= l_err_d;
      end
   end

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: RAM model, fetch/loader drivers, scoreboard of expected fetch returns.
// Works with and without IMEM_RANGE_CHECK_EN defined.
module tb_imem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        f_req;
   logic [31:0] f_pc;
   logic        f_gnt;
   logic        f_rvalid;
   logic [31:0] f_instr;
   logic        f_fault;
   logic        l_req;
   logic [31:0] l_addr;
   logic [31:0] l_wdata;
   logic        l_gnt;
   logic        l_err;
   logic        ram_en;
   logic        ram_we;
   logic [11:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;

   // clock / reset block
   always #5 clk = ~clk;

   imem_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .f_req     (f_req),
      .f_pc      (f_pc),
      .f_gnt     (f_gnt),
      .f_rvalid  (f_rvalid),
      .f_instr   (f_instr),
      .f_fault   (f_fault),
      .l_req     (l_req),
      .l_addr    (l_addr),
      .l_wdata   (l_wdata),
      .l_gnt     (l_gnt),
      .l_err     (l_err),
      .ram_en    (ram_en),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   // RAM model with a backdoor preload port
   bit [31:0]   ram [4096];
   bit [31:0]   shadow [4096];
   logic        bd_we = 1'b0;
   logic [11:0] bd_addr = 12'd0;
   logic [31:0] bd_data = 32'd0;

   always @(posedge clk) begin
      if (bd_we) ram[bd_addr] <= bd_data;
      else if (ram_en && ram_we) ram[ram_addr] <= ram_wdata;
      else if (ram_en) ram_rdata <= ram[ram_addr];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard
   logic [32:0] exp_q[$];
   int          cyc_q[$];
   int          n_vec = 0;
   int          n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [11:0] word_idx(input logic [31:0] a);
      logic [31:0] o;
      o = a - 32'h0000_3000;
      return o[13:2];
   endfunction

   function automatic logic is_bad(input logic [31:0] a);
`ifdef IMEM_RANGE_CHECK_EN
      return (a[1:0] != 2'b00) || (a < 32'h0000_3000) || (a >= 32'h0000_7000);
`else
      return 1'b0 && a[0];
`endif
   endfunction

   logic [32:0] mon_e;
   int          mon_c;
   always @(negedge clk) begin
      if (f_rvalid) begin
         if (exp_q.size() == 0) begin
            check_eq("rv_spurious", {31'd0, f_rvalid}, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            mon_c = cyc_q.pop_front();
            check_eq("f_instr", f_instr, mon_e[31:0]);
            check_eq("f_fault", {31'd0, f_fault}, {31'd0, mon_e[32]});
            check_eq("rv_latency", cyc, mon_c);
         end
      end
   end

   // driver tasks: all start and end at posedge+1
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_fetch(input logic [31:0] pc, output int waited);
      logic bad;
      logic got;
      bad = is_bad(pc);
      f_req = 1'b1;
      f_pc  = pc;
      waited = 0;
      got = 1'b0;
      while (!got && waited < 8) begin
         @(negedge clk);
         if (f_gnt) got = 1'b1;
         else begin
            waited++;
            tick(1);
         end
      end
      if (got) begin
         check_eq("f_ram_en", {31'd0, ram_en}, {31'd0, !bad});
         check_eq("f_ram_we", {31'd0, ram_we}, 32'd0);
         if (!bad) check_eq("f_ram_addr", {20'd0, ram_addr}, {20'd0, word_idx(pc)});
         exp_q.push_back({bad, bad ? 32'h0 : shadow[word_idx(pc)]});
         cyc_q.push_back(cyc + 1);
         tick(1);
      end else begin
         check_eq("f_gnt_timeout", {31'd0, f_gnt}, 32'd1);
      end
      f_req = 1'b0;
   endtask

   task automatic do_load(input logic [31:0] a, input logic [31:0] d, output int waited);
      logic bad;
      logic got;
      bad = is_bad(a);
      l_req   = 1'b1;
      l_addr  = a;
      l_wdata = d;
      waited = 0;
      got = 1'b0;
      while (!got && waited < 12) begin
         @(negedge clk);
         if (l_gnt) got = 1'b1;
         else begin
            waited++;
            tick(1);
         end
      end
      if (got) begin
         check_eq("l_ram_en", {31'd0, ram_en}, {31'd0, !bad});
         check_eq("l_ram_we", {31'd0, ram_we}, {31'd0, !bad});
         if (!bad) begin
            check_eq("l_ram_addr", {20'd0, ram_addr}, {20'd0, word_idx(a)});
            check_eq("l_ram_wdata", ram_wdata, d);
            shadow[word_idx(a)] = d;
         end
         tick(1);
      end else begin
         check_eq("l_gnt_timeout", {31'd0, l_gnt}, 32'd1);
      end
      l_req = 1'b0;
   endtask

   task automatic fetch_abc();
      int w;
      do_fetch(32'h0000_3000, w);
      check_eq("abc_wait0", w, 0);
      do_fetch(32'h0000_3004, w);
      check_eq("abc_wait1", w, 0);
      do_fetch(32'h0000_3008, w);
      check_eq("abc_wait2", w, 0);
      tick(1);
      @(negedge clk);
      check_eq("abc_hold_rv", {31'd0, f_rvalid}, 32'd0);
      check_eq("abc_hold_instr", f_instr, 32'h0000_000C);
      tick(1);
   endtask

   initial begin
      int          w;
      int          j;
      logic        ldone;
      logic [31:0] v;
      reset = 1'b0;
      f_req = 1'b1;
      f_pc  = 32'h0000_3000;
      l_req = 1'b1;
      l_addr = 32'h0000_3000;
      l_wdata = 32'h0;

      // preload while reset is held; grants must stay low throughout
      for (int i = 0; i < 32; i++) begin
         v = (i == 0) ? 32'hA : (i == 1) ? 32'hB : (i == 2) ? 32'hC : $urandom;
         shadow[i] = v;
         bd_we = 1'b1;
         bd_addr = 12'(i);
         bd_data = v;
         @(negedge clk);
         if (i < 3) begin
            check_eq("rst_f_gnt", {31'd0, f_gnt}, 32'd0);
            check_eq("rst_l_gnt", {31'd0, l_gnt}, 32'd0);
            check_eq("rst_ram_en", {31'd0, ram_en}, 32'd0);
         end
         tick(1);
      end
      bd_we = 1'b0;
      f_req = 1'b0;
      l_req = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      check_eq("rst_rvalid", {31'd0, f_rvalid}, 32'd0);
      check_eq("rst_instr", f_instr, 32'd0);
      check_eq("rst_fault", {31'd0, f_fault}, 32'd0);
      check_eq("rst_l_err", {31'd0, l_err}, 32'd0);
      tick(1);

      // back-to-back fetches
      fetch_abc();

      // write then fetch during the write turnaround
      do_load(32'h0000_4180, 32'h1234_5678, w);
      check_eq("ld_wait", w, 0);
      do_fetch(32'h0000_4180, w);
      check_eq("wt_fetch_wait", w, 1);
      tick(2);

      // starvation: continuous fetch, loader raised at k=10
      f_req = 1'b1;
      j = 0;
      ldone = 1'b0;
      for (int k = 0; k < 22; k++) begin
         f_pc = 32'h0000_3000 + 32'(4 * j);
         l_req = (k >= 10) && !ldone;
         l_addr = 32'h0000_3044;
         l_wdata = 32'hDEAD_BEEF;
         @(negedge clk);
         check_eq("st_l_gnt", {31'd0, l_gnt}, {31'd0, (k == 14)});
         check_eq("st_f_gnt", {31'd0, f_gnt}, {31'd0, !(k == 14 || k == 15)});
         if (l_gnt) begin
            check_eq("st_we", {31'd0, ram_we}, 32'd1);
            check_eq("st_waddr", {20'd0, ram_addr}, 32'd17);
            shadow[17] = 32'hDEAD_BEEF;
            ldone = 1'b1;
         end
         if (f_gnt) begin
            exp_q.push_back({1'b0, shadow[word_idx(f_pc)]});
            cyc_q.push_back(cyc + 1);
            j++;
         end
         tick(1);
      end
      f_req = 1'b0;
      l_req = 1'b0;
      tick(2);

`ifdef IMEM_RANGE_CHECK_EN
      do_fetch(32'h0000_2FFC, w);
      do_fetch(32'h0000_3002, w);
      do_fetch(32'h0000_7000, w);
      tick(1);
      do_load(32'h0000_7000, 32'h5555_AAAA, w);
      f_req = 1'b1;
      f_pc  = 32'h0000_3004;
      @(negedge clk);
      check_eq("l_err_pulse", {31'd0, l_err}, 32'd1);
      check_eq("no_wt_gnt", {31'd0, f_gnt}, 32'd1);
      exp_q.push_back({1'b0, shadow[1]});
      cyc_q.push_back(cyc + 1);
      tick(1);
      f_req = 1'b0;
      @(negedge clk);
      check_eq("l_err_clear", {31'd0, l_err}, 32'd0);
      tick(2);
`else
      do_fetch(32'h0000_7000, w);
      tick(1);
      @(negedge clk);
      check_eq("wrap_instr", f_instr, 32'h0000_000A);
      tick(1);
`endif

      // reset while a read is in flight
      do_fetch(32'h0000_3008, w);
      reset = 1'b0;
      f_req = 1'b1;
      @(negedge clk);
      check_eq("rif_rvalid", {31'd0, f_rvalid}, 32'd0);
      check_eq("rif_f_gnt", {31'd0, f_gnt}, 32'd0);
      void'(exp_q.pop_back());
      void'(cyc_q.pop_back());
      tick(1);
      reset = 1'b1;
      f_req = 1'b0;
      @(negedge clk);
      check_eq("rif_instr", f_instr, 32'd0);
      check_eq("rif_rvalid2", {31'd0, f_rvalid}, 32'd0);
      tick(1);
      fetch_abc();

      tick(3);
      check_eq("drain", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
